// File: rtl/store_narrower_pkg.sv
// Shared encodings and helpers for the byte-serial store narrower.
// The sign-extension checker is also meant to be reused on the load side.
package store_narrower_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: beat_count = 3'd1;
            SZ_HALF: beat_count = 3'd2;
            default: beat_count = 3'd4;
        endcase
    endfunction

    // Illegal size or a start address that is not naturally aligned.
    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: req_illegal = 1'b0;
            SZ_HALF: req_illegal = addr_lo[0];
            SZ_WORD: req_illegal = (addr_lo != 2'b00);
            default: req_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_narrower_narrow_check.sv
// Combinational inverse of the sign extender: flags values whose narrowed
// field would not sign-extend back to the full 32-bit register value.
module store_narrower_narrow_check
    import store_narrower_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    output logic        o_ovf
);

    always_comb begin
        o_ovf = 1'b0;
        case (i_size)
            SZ_BYTE: o_ovf = (i_data[31:8]  != {24{i_data[7]}});
            SZ_HALF: o_ovf = (i_data[31:16] != {16{i_data[15]}});
            default: o_ovf = 1'b0;
        endcase
    end

endmodule

// File: rtl/store_narrower.sv
// Narrows a register value to byte/half/word and writes it out as serial
// little-endian 8-bit beats on a byte-wide memory port.
module store_narrower
    import store_narrower_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              err,
    output logic              trunc_ovf,
    output logic              busy
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [1:0]        r_k;
    logic [1:0]        r_last;
    logic              r_ovf;
    logic              r_done;
    logic              r_err;
    logic              r_trunc;
    logic              w_accept;
    logic              w_ovf;
    logic [2:0]        w_n;

    store_narrower_narrow_check u_check (
        .i_data (req_data),
        .i_size (req_size),
        .o_ovf  (w_ovf)
    );

    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_n      = beat_count(req_size);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)
                         w_next = req_illegal(req_size, req_addr[1:0]) ? ST_ERR : ST_SEND;
            ST_SEND: if (mem_ack && (r_k == r_last))
                         w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_k     <= '0;
            r_last  <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == ST_FIN);
            r_err   <= (w_next == ST_ERR);
            r_trunc <= (w_next == ST_FIN) ? r_ovf : 1'b0;
            if (w_accept) begin
                r_addr <= req_addr;
                r_data <= req_data;
                r_last <= w_n[1:0] - 2'd1;
                r_k    <= 2'd0;
                r_ovf  <= w_ovf;
            end else if ((r_state == ST_SEND) && mem_ack && (r_k != r_last)) begin
                r_k <= r_k + 2'd1;
            end
        end
    end

    // Beat outputs decode only registered state, so they hold through wait states.
    always_comb begin
        mem_wdata = r_data[7:0];
        case (r_k)
            2'd0: mem_wdata = r_data[7:0];
            2'd1: mem_wdata = r_data[15:8];
            2'd2: mem_wdata = r_data[23:16];
            2'd3: mem_wdata = r_data[31:24];
            default: mem_wdata = r_data[7:0];
        endcase
    end

    assign mem_addr  = r_addr + ADDR_W'(r_k);
    assign mem_we    = (r_state == ST_SEND);
    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign trunc_ovf = r_trunc;

endmodule

// File: tb/tb_store_narrower.sv
// Randomized and directed checks of store_narrower against a behavioural
// model of the narrowing rules and beat sequence.
module tb_store_narrower;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic              done;
    logic              err;
    logic              trunc_ovf;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_narrower #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .done      (done),
        .err       (err),
        .trunc_ovf (trunc_ovf),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Entered and left on a negedge with the block idle.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input int dly);
        bit bad;
        bit ovf;
        int n;
        int sd;
        sd  = $signed(d);
        bad = (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        ovf = (sz == 2'b00) ? (sd < -128 || sd > 127) :
              (sz == 2'b01) ? (sd < -32768 || sd > 32767) : 1'b0;
        chk("ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        if (bad) begin
            chk("err_pulse", err, 1);
            chk("err_no_we", mem_we, 0);
            chk("err_not_ready", req_ready, 0);
            @(negedge clk);
            chk("err_drop", err, 0);
            chk("err_ready_back", req_ready, 1);
            chk("err_no_we2", mem_we, 0);
        end else begin
            for (int i = 0; i < n; i++) begin
                for (int w = 0; w <= dly; w++) begin
                    chk("beat_we", mem_we, 1);
                    chk("beat_addr", mem_addr, a + 32'(i));
                    chk("beat_data", 32'(mem_wdata), (d >> (8 * i)) & 32'hFF);
                    chk("beat_no_done", done, 0);
                    mem_ack = (w == dly);
                    @(negedge clk);
                end
            end
            mem_ack = 1'b0;
            chk("done_pulse", done, 1);
            chk("done_trunc", trunc_ovf, 32'(ovf));
            chk("done_no_we", mem_we, 0);
            chk("done_not_ready", req_ready, 0);
            @(negedge clk);
            chk("done_drop", done, 0);
            chk("trunc_drop", trunc_ovf, 0);
            chk("ready_after", req_ready, 1);
        end
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] edges [8];
        edges = '{32'd127, 32'd128, 32'hFFFFFF80, 32'hFFFFFF7F,
                  32'd32767, 32'd32768, 32'hFFFF8000, 32'hFFFF7FFF};
        case ($urandom_range(0, 3))
            0:       rand_data = $urandom;
            1:       rand_data = 32'($urandom_range(0, 255)) - 32'd128;
            2:       rand_data = 32'($urandom_range(0, 65535)) - 32'd32768;
            default: rand_data = edges[$urandom_range(0, 7)];
        endcase
    endfunction

    initial begin
        logic [15:0] beats [$];
        logic [31:0] ra;
        int dones;
        bit second;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = 2'b00;
        mem_ack   = 1'b0;
        @(negedge clk);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_trunc", trunc_ovf, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_post_rst", req_ready, 1);

        run_store(32'h1003, 32'hFFFFFF80, 2'b00, 0);
        run_store(32'h2002, 32'h00018000, 2'b01, 0);
        run_store(32'h3000, 32'h12345678, 2'b10, 2);
        run_store(32'h4001, 32'h0, 2'b01, 0);
        run_store(32'h4002, 32'h0, 2'b10, 0);
        run_store(32'h4000, 32'h0, 2'b11, 0);

        // Reset with the third word beat on the bus.
        req_valid = 1'b1;
        req_addr  = 32'h5000;
        req_data  = 32'hA1B2C3D4;
        req_size  = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("mid_we", mem_we, 1);
        chk("mid_addr", mem_addr, 32'h5002);
        rst_n = 1'b0;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("arst_quiet_done", done, 0);
            chk("arst_quiet_we", mem_we, 0);
            chk("arst_ready", req_ready, 1);
        end
        run_store(32'h6001, 32'h0000007F, 2'b00, 0);

        // Spurious acks while idle.
        mem_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("spur_we", mem_we, 0);
            chk("spur_busy", busy, 0);
            chk("spur_done", done, 0);
        end

        // Valid held high across two byte requests, ack tied high.
        req_valid = 1'b1;
        req_addr  = 32'h10;
        req_data  = 32'h11;
        req_size  = 2'b00;
        dones     = 0;
        second    = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 0) begin
                req_addr = 32'h20;
                req_data = 32'h22;
            end
            if (done) dones++;
            if (mem_we) begin
                beats.push_back({mem_addr[7:0], mem_wdata});
                if (mem_addr == 32'h20) req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        chk("b2b_dones", dones, 2);
        chk("b2b_beats", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("b2b_beat0", 32'(beats[0]), 32'h1011);
            chk("b2b_beat1", 32'(beats[1]), 32'h2022);
        end
        @(negedge clk);
        chk("b2b_idle", req_ready, 1);

        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            run_store(ra, rand_data(), 2'($urandom_range(0, 3)), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/store_narrower.md
Name: store_narrower

Overview:
- Store-side counterpart of the datapath's 16->32 immediate sign extension: narrows a 32-bit register value to a byte, halfword or word and writes it to a byte-wide data memory port as serial 8-bit beats.
- Flags when narrowing loses information, i.e. when the stored field would not sign-extend back to the original register value.
- Sits between the execute stage (sb/sh/sw requests) and the byte-wide data RAM.

Parameters:
- ADDR_W, 32, width of the request and memory addresses.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_W  byte address of the store.
- req_data  in  32  register value to store.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- mem_we  out  1  write strobe, held until mem_ack.
- mem_addr  out  ADDR_W  byte address of the current beat.
- mem_wdata  out  8  byte of the current beat.
- mem_ack  in  1  memory accepted the current beat.
- done  out  1  one-cycle pulse, store completed.
- err  out  1  one-cycle pulse, request rejected (misaligned or illegal size).
- trunc_ovf  out  1  narrowing lost information; valid only while done=1.
- busy  out  1  request in flight (state != IDLE).

Behaviour:
- Reset (async, rst_n=0): state IDLE. mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, trunc_ovf=0, busy=0. Beat counter and captured request cleared. Asserting reset mid-store drops mem_we immediately; the partial store is not completed and not reported.
- After reset release, req_ready=1 from the first clock edge.
- States: IDLE, SEND, FIN, ERR.
- req_ready = (state==IDLE), combinational from state.
- IDLE: on req_valid && req_ready, capture addr, data and size.
  - If size==11, or size==01 with addr[0]!=0, or size==10 with addr[1:0]!=0: go to ERR.
  - Otherwise go to SEND with beat counter k=0 and beat count N=1/2/4 for byte/half/word.
  - trunc_ovf is computed at accept and registered:
    - byte: data[31:8] != {24{data[7]}}
    - half: data[31:16] != {16{data[15]}}
    - word: always 0
- SEND:
  - Outputs: mem_we=1, mem_addr = captured addr + k, mem_wdata = data[8k+7:8k] (little-endian).
  - On mem_ack: if k==N-1 go to FIN, else k<=k+1.
  - mem_addr, mem_wdata and mem_we stay stable while mem_ack=0. There is no timeout.
- FIN: done=1 for exactly one cycle, trunc_ovf presented, then go to IDLE. req_ready=0 in FIN.
- ERR: err=1 for exactly one cycle, no memory writes, then go to IDLE.
- mem_ack is ignored when mem_we=0.
- req_valid outside IDLE is ignored. The requester must hold its request until req_ready is high.
- Latency: accept at edge T gives first mem_we in cycle T+1. With zero-wait ack, done is high in cycle T+1+N, and the next accept is possible at T+2+N.
- mem_addr is computed modulo 2^ADDR_W. Aligned requests never carry out of the word.
- done, err and trunc_ovf are registered outputs. mem_we, mem_addr and mem_wdata are registered or decoded from registered state only, never combinational from inputs.

Decomposition:
- Shared package / header:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - FSM state encodings
  - beat-count function size->N
- Natural sub-module: narrow_check, purely combinational (data, size) -> trunc_ovf. It is the logical inverse of the sign extender and is reusable by load-side checks.

Test Plan:
- Byte store: addr=0x1003, data=0xFFFFFF80, size=00, immediate ack -> one beat (0x1003, 0x80); done at accept+2; trunc_ovf=0.
- Halfword store, overflow: addr=0x2002, data=0x00018000, size=01 -> beats (0x2002,0x00), (0x2003,0x80); trunc_ovf=1.
- Word store with wait states: addr=0x3000, data=0x12345678, ack delayed 2 cycles per beat -> beats 78,56,34,12 at 0x3000..0x3003, outputs stable during wait, done once, trunc_ovf=0.
- Misaligned and illegal: addr=0x4001 size=01, then addr=0x4002 size=10, then size=11 -> err pulse each, mem_we never asserted, req_ready back one cycle later.
- Reset mid-operation: word store, rst_n low after the 2nd ack -> mem_we=0 asynchronously, no done; after release req_ready=1 and a new byte store completes normally.
- Back-to-back and spurious: req_valid held high across two requests, and mem_ack pulsed while idle -> second request accepted only in IDLE, spurious ack ignored, exactly two done pulses.
